// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Purpose  : Shared AES-128 types, constant tables and GF(2^8) helpers used by
//            the iterative inverse cipher. Byte 0 of a block lives in bits
//            [127:120] (FIPS-197 byte order). Column c of the state is bytes
//            4c..4c+3, with row 0 in the most significant byte of the column.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEXP  = 3'd1,
    S_READY = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] c_inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Round constants Rcon(1)..Rcon(10).
  localparam byte_t c_rcon [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Table entry b sits at bits [2047-8b -: 8]; 2047-8b is simply {~b, 3'b111}.
  function automatic byte_t sbox(input byte_t b);
    return c_sbox[{~b, 3'b111} -: 8];
  endfunction

  function automatic byte_t inv_sbox(input byte_t b);
    return c_inv_sbox[{~b, 3'b111} -: 8];
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic byte_t gf_xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Undo xtime: an odd input means the reduction polynomial was folded in,
  // so the original top bit was 1.
  function automatic byte_t gf_inv_xtime(input byte_t b);
    return b[0] ? {1'b1, b[7:1] ^ 7'h0d} : {1'b0, b[7:1]};
  endfunction

  // InvMixColumns on one column: multiply by {0e,0b,0d,09} circulant.
  function automatic word_t inv_mix_column(input word_t col);
    byte_t a  [4];
    byte_t m9 [4];
    byte_t mb [4];
    byte_t md [4];
    byte_t me [4];
    byte_t x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = gf_xtime(a[i]);
      x4    = gf_xtime(x2);
      x8    = gf_xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_round
// Purpose  : One combinational AES inverse round:
//            InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns,
//            with InvMixColumns bypassed on the final round.
// Ports    : state_in   - round input state
//            round_key  - round key to add
//            last_round - 1 skips InvMixColumns
//            state_out  - round output state
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_round (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);
  import aes_pkg::*;

  block_t w_sub;
  block_t w_ark;
  block_t w_imc;

  // Row r rotates right by r: output (row r, col c) takes input (row r, col c-r).
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int c_row     = gi % 4;
      localparam int c_src_col = ((gi / 4) - c_row + 4) % 4;
      localparam int c_src     = c_src_col * 4 + c_row;
      assign w_sub[127-8*gi -: 8] = inv_sbox(state_in[127-8*c_src -: 8]);
    end
  endgenerate

  assign w_ark = w_sub ^ round_key;

  genvar gc;
  generate
    for (gc = 0; gc < 4; gc++) begin : g_col
      assign w_imc[127-32*gc -: 32] = inv_mix_column(w_ark[127-32*gc -: 32]);
    end
  endgenerate

  assign state_out = last_round ? w_ark : w_imc;

endmodule
`default_nettype wire

// File: rtl/aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes128_decrypt_iter
// Purpose  : Iterative AES-128 inverse cipher, one round per clock. A loaded
//            key is expanded forward once to the round-10 key (held in
//            r_rk10); each block then walks the schedule backwards on the fly.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            key/key_valid/key_ready    - cipher key handshake
//            cipher_text/ct_valid/ct_ready - ciphertext block handshake
//            plain_text/pt_valid/pt_ready  - registered result handshake
//            key_loaded                 - a usable round-10 key is held
// Revision : 1.0 - initial release
// ============================================================================
module aes128_decrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] cipher_text,
  input  logic         ct_valid,
  output logic         ct_ready,
  output logic [127:0] plain_text,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic         key_loaded
);
  import aes_pkg::*;

  localparam logic [3:0] c_last = 4'(NR - 1);

  state_t r_state;
  state_t w_next_state;
  block_t r_rk10;
  block_t r_rk;        // forward-expansion key in KEXP, current round key in ROUND
  block_t r_data;
  block_t r_plain;
  byte_t  r_rcon;
  logic [3:0] r_cnt;
  logic   r_key_loaded;

  logic   w_key_ready;
  word_t  w_fw0, w_fw1, w_fw2, w_fw3;
  word_t  w_bk0, w_bk1, w_bk2, w_bk3;
  block_t w_rk_fwd;
  block_t w_rk_back;
  block_t w_round_out;

  // Forward key-schedule step.
  assign w_fw0    = r_rk[127:96] ^ sub_word(rot_word(r_rk[31:0])) ^ {r_rcon, 24'h0};
  assign w_fw1    = r_rk[95:64] ^ w_fw0;
  assign w_fw2    = r_rk[63:32] ^ w_fw1;
  assign w_fw3    = r_rk[31:0]  ^ w_fw2;
  assign w_rk_fwd = {w_fw0, w_fw1, w_fw2, w_fw3};

  // Inverse step: words 3..1 undo the xor chain, then word 0 needs the
  // recovered word 3 to rebuild the SubWord/RotWord/Rcon term.
  assign w_bk3     = r_rk[31:0]  ^ r_rk[63:32];
  assign w_bk2     = r_rk[63:32] ^ r_rk[95:64];
  assign w_bk1     = r_rk[95:64] ^ r_rk[127:96];
  assign w_bk0     = r_rk[127:96] ^ sub_word(rot_word(w_bk3)) ^ {r_rcon, 24'h0};
  assign w_rk_back = {w_bk0, w_bk1, w_bk2, w_bk3};

  aes_inv_round u_inv_round (
    .state_in   (r_data),
    .round_key  (w_rk_back),
    .last_round (r_cnt == 4'd0),
    .state_out  (w_round_out)
  );

  // A ciphertext offered in READY wins over a simultaneous key offer; the key
  // stays pending and is taken once the block has been returned.
  assign w_key_ready = (r_state == S_IDLE) || ((r_state == S_READY) && !ct_valid);
  assign key_ready   = w_key_ready;
  assign ct_ready    = (r_state == S_READY);
  assign pt_valid    = (r_state == S_DONE);
  assign plain_text  = r_plain;
  assign key_loaded  = r_key_loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (key_valid) w_next_state = S_KEXP;
      S_KEXP:  if (r_cnt == c_last) w_next_state = S_READY;
      S_READY: begin
        if (ct_valid)       w_next_state = S_ROUND;
        else if (key_valid) w_next_state = S_KEXP;
      end
      S_ROUND: if (r_cnt == 4'd0) w_next_state = S_DONE;
      S_DONE:  if (pt_ready) w_next_state = S_READY;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk10       <= '0;
      r_rk         <= '0;
      r_data       <= '0;
      r_plain      <= '0;
      r_rcon       <= '0;
      r_cnt        <= '0;
      r_key_loaded <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (key_valid) begin
            r_rk         <= key;
            r_rcon       <= c_rcon[0];
            r_cnt        <= '0;
            r_key_loaded <= 1'b0;
          end
        end
        S_KEXP: begin
          r_rk   <= w_rk_fwd;
          r_rcon <= gf_xtime(r_rcon);
          r_cnt  <= r_cnt + 4'd1;
          if (r_cnt == c_last) begin
            r_rk10       <= w_rk_fwd;
            r_key_loaded <= 1'b1;
          end
        end
        S_READY: begin
          if (ct_valid) begin
            r_data <= cipher_text ^ r_rk10;
            r_rk   <= r_rk10;
            r_rcon <= c_rcon[NR-1];
            r_cnt  <= c_last;
          end else if (key_valid) begin
            r_rk         <= key;
            r_rcon       <= c_rcon[0];
            r_cnt        <= '0;
            r_key_loaded <= 1'b0;
          end
        end
        S_ROUND: begin
          r_data <= w_round_out;
          r_rk   <= w_rk_back;
          r_rcon <= gf_inv_xtime(r_rcon);
          if (r_cnt == 4'd0) begin
            r_plain <= w_round_out;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
